// File: rtl/read_cycle_pkg.sv
// Shared SRAM constants, read FSM encoding and pin decode helpers, common to the
// read and write cycle generators.
package read_cycle_pkg;

  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 8;
  localparam int FACTOR_W    = 8;
  localparam int CYCLE_CNT_W = 10;

  localparam logic [SRAM_ADDR_W-1:0] SRAM_ADDR_IDLE = 9'h1FF;
  localparam logic [SRAM_DATA_W-1:0] SRAM_DATA_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLK_LOW  = 3'd1,
    ST_ADDR     = 3'd2,
    ST_CLK_HIGH = 3'd3,
    ST_SAMPLE   = 3'd4,
    ST_DONE     = 3'd5
  } rd_state_t;

  // SRAM clock is low only while the address is being set up.
  function automatic logic pin_clk(input rd_state_t s);
    return !(s == ST_CLK_LOW || s == ST_ADDR);
  endfunction

  function automatic logic pin_cen(input rd_state_t s);
    return !(s == ST_ADDR || s == ST_CLK_HIGH);
  endfunction

  function automatic logic addr_driven(input rd_state_t s);
    return (s == ST_ADDR) || (s == ST_CLK_HIGH) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/read_cycle_timer.sv
// Phase counter for one SRAM access; decodes the 2F, 4F-1 and 4F thresholds
// against the count value that the next clock edge will load.
module read_cycle_timer
  import read_cycle_pkg::*;
#(
  parameter int CNT_W = CYCLE_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic [FACTOR_W-1:0] factor,
  output logic                at_launch,
  output logic                at_sample,
  output logic                at_done
);

  logic [FACTOR_W-1:0] f_q;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic [CNT_W-1:0]    two_f;
  logic [CNT_W-1:0]    four_f;

  function automatic logic [FACTOR_W-1:0] clamp_factor(input logic [FACTOR_W-1:0] f);
    return (f == '0) ? FACTOR_W'(1) : f;
  endfunction

  always_comb begin
    two_f     = CNT_W'({f_q, 1'b0});
    four_f    = CNT_W'({f_q, 2'b00});
    count_nxt = count;
    if (load) begin
      count_nxt = '0;
    end else if (run) begin
      count_nxt = count + CNT_W'(1);
    end
    at_launch = (count_nxt == two_f);
    at_sample = (count_nxt == four_f - CNT_W'(1));
    at_done   = (count_nxt == four_f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      f_q   <= FACTOR_W'(1);
    end else begin
      count <= count_nxt;
      if (load) begin
        f_q <= clamp_factor(factor);
      end
    end
  end

endmodule

// File: rtl/read_cycle.sv
// SRAM read cycle generator: drives one read per start request, captures the
// returned word, compares it with the expected value and counts mismatches.
module read_cycle
  import read_cycle_pkg::*;
#(
  parameter int CNT_W = CYCLE_CNT_W,
  parameter int ERR_W = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [FACTOR_W-1:0]    clk_factor,
  input  logic                   start_in,
  input  logic [SRAM_ADDR_W-1:0] a_in,
  input  logic [SRAM_DATA_W-1:0] exp_in,
  input  logic [SRAM_DATA_W-1:0] q_in,
  output logic                   clk_out,
  output logic                   cen_out,
  output logic                   wen_out,
  output logic [SRAM_ADDR_W-1:0] a_out,
  output logic [SRAM_DATA_W-1:0] q_out,
  output logic                   valid_out,
  output logic                   mismatch_out,
  output logic [ERR_W-1:0]       err_count,
  output logic                   reading
);

  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic                   start_q;
  rd_state_t              state;
  rd_state_t              state_nxt;
  logic                   load;
  logic                   run;
  logic                   at_launch;
  logic                   at_sample;
  logic                   at_done;
  logic                   capture;
  logic                   differs;
  logic [SRAM_DATA_W-1:0] exp_q;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Reset asserts immediately, releases two edges later.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n   = rst_sync[1];
  assign wen_out = 1'b1;

  read_cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run),
    .factor   (clk_factor),
    .at_launch(at_launch),
    .at_sample(at_sample),
    .at_done  (at_done)
  );

  // Requests are only accepted while fully idle; anything else is dropped.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      start_q <= start_in && (state == ST_IDLE);
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_q) begin
          state_nxt = ST_CLK_LOW;
          load      = 1'b1;
        end
      end
      ST_CLK_LOW: begin
        run       = 1'b1;
        state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        run = 1'b1;
        if (at_launch) state_nxt = ST_CLK_HIGH;
      end
      ST_CLK_HIGH: begin
        run = 1'b1;
        if (at_sample) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        run = 1'b1;
        if (at_done) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign capture = (state == ST_SAMPLE) && (state_nxt == ST_DONE);
  assign differs = (q_in != exp_q);

  // Pins are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_out   <= 1'b1;
      cen_out   <= 1'b1;
      a_out     <= SRAM_ADDR_IDLE;
      reading   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      clk_out   <= pin_clk(state_nxt);
      cen_out   <= pin_cen(state_nxt);
      reading   <= (state_nxt != ST_IDLE);
      valid_out <= (state_nxt == ST_DONE);
      if (!addr_driven(state_nxt)) begin
        a_out <= SRAM_ADDR_IDLE;
      end else if (state == ST_CLK_LOW) begin
        a_out <= a_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (state == ST_CLK_LOW) begin
      exp_q <= exp_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q_out        <= SRAM_DATA_IDLE;
      mismatch_out <= 1'b0;
      err_count    <= '0;
    end else if (capture) begin
      q_out        <= q_in;
      mismatch_out <= differs;
      if (differs) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_read_cycle.sv
// Directed bench for read_cycle: one full-width instance and a 2-bit error
// counter instance sharing the same stimulus.
module tb_read_cycle;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] clk_factor;
  logic       start_in;
  logic [8:0] a_in;
  logic [7:0] exp_in;
  logic [7:0] q_in;

  logic        clk_out, cen_out, wen_out, valid_out, mismatch_out, reading;
  logic [8:0]  a_out;
  logic [7:0]  q_out;
  logic [15:0] err_count;

  logic       s_clk_out, s_cen_out, s_wen_out, s_valid_out, s_mismatch_out, s_reading;
  logic [8:0] s_a_out;
  logic [7:0] s_q_out;
  logic [1:0] s_err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  read_cycle dut (
    .clk_in(clk_in), .reset_in(reset_in), .clk_factor(clk_factor), .start_in(start_in),
    .a_in(a_in), .exp_in(exp_in), .q_in(q_in),
    .clk_out(clk_out), .cen_out(cen_out), .wen_out(wen_out), .a_out(a_out),
    .q_out(q_out), .valid_out(valid_out), .mismatch_out(mismatch_out),
    .err_count(err_count), .reading(reading)
  );

  read_cycle #(.ERR_W(2)) dut_s (
    .clk_in(clk_in), .reset_in(reset_in), .clk_factor(clk_factor), .start_in(start_in),
    .a_in(a_in), .exp_in(exp_in), .q_in(q_in),
    .clk_out(s_clk_out), .cen_out(s_cen_out), .wen_out(s_wen_out), .a_out(s_a_out),
    .q_out(s_q_out), .valid_out(s_valid_out), .mismatch_out(s_mismatch_out),
    .err_count(s_err_count), .reading(s_reading)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_read(input logic [7:0] f, input logic [8:0] a,
                            input logic [7:0] e, input logic [7:0] q);
    clk_factor = f;
    a_in       = a;
    exp_in     = e;
    q_in       = q;
    start_in   = 1'b1;
    @(negedge clk_in);
    start_in   = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid_out !== 1'b1 && n < 1100) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_valid_seen"}, valid_out, 1'b1);
  endtask

  logic [9:0] n_clk, n_cen, n_val, n_rd, n_adr;
  logic [5:0] o_clk, o_cen, o_val, o_mis, o_adr;
  int         sat_small[5];
  int         nv, vpos, nfall;
  logic       prev_rd;

  initial begin
    reset_in   = 1'b0;
    clk_factor = 8'd0;
    start_in   = 1'b0;
    a_in       = 9'd0;
    exp_in     = 8'd0;
    q_in       = 8'd0;

    repeat (2) @(negedge clk_in);
    check("rst_clk", clk_out, 1'b1);
    check("rst_cen", cen_out, 1'b1);
    check("rst_wen", wen_out, 1'b1);
    check("rst_a", a_out, 9'h1FF);
    check("rst_q", q_out, 8'hFF);
    check("rst_valid", valid_out, 1'b0);
    check("rst_mis", mismatch_out, 1'b0);
    check("rst_err", err_count, 16'd0);
    check("rst_reading", reading, 1'b0);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Nominal read, F = 2: bit k is the expected value at counter k.
    n_clk = 10'b11_1111_0000;
    n_cen = 10'b11_1000_0001;
    n_val = 10'b01_0000_0000;
    n_rd  = 10'b01_1111_1111;
    n_adr = 10'b00_1111_1110;
    start_read(8'd2, 9'h0A5, 8'h3C, 8'h3C);
    check("nom_latency_reading", reading, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      check($sformatf("nom_clk_c%0d", k), clk_out, n_clk[k]);
      check($sformatf("nom_cen_c%0d", k), cen_out, n_cen[k]);
      check($sformatf("nom_valid_c%0d", k), valid_out, n_val[k]);
      check($sformatf("nom_reading_c%0d", k), reading, n_rd[k]);
      check($sformatf("nom_wen_c%0d", k), wen_out, 1'b1);
      check($sformatf("nom_a_c%0d", k), a_out, n_adr[k] ? 9'h0A5 : 9'h1FF);
      if (k == 8) begin
        check("nom_q", q_out, 8'h3C);
        check("nom_mis", mismatch_out, 1'b0);
        check("nom_err", err_count, 16'd0);
      end
    end

    // Mismatching read.
    start_read(8'd2, 9'h0A5, 8'h3C, 8'h3D);
    wait_valid("mis");
    check("mis_q", q_out, 8'h3D);
    check("mis_flag", mismatch_out, 1'b1);
    check("mis_err", err_count, 16'd1);
    repeat (3) @(negedge clk_in);
    check("mis_hold", mismatch_out, 1'b1);
    check("mis_valid_low", valid_out, 1'b0);

    // clk_factor = 0 behaves as F = 1; mismatch flag held until this valid.
    o_clk = 6'b11_1100;
    o_cen = 6'b11_1001;
    o_val = 6'b01_0000;
    o_mis = 6'b00_1111;
    o_adr = 6'b00_1110;
    start_read(8'd0, 9'h155, 8'h5A, 8'h5A);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      check($sformatf("f0_clk_c%0d", k), clk_out, o_clk[k]);
      check($sformatf("f0_cen_c%0d", k), cen_out, o_cen[k]);
      check($sformatf("f0_valid_c%0d", k), valid_out, o_val[k]);
      check($sformatf("f0_mis_c%0d", k), mismatch_out, o_mis[k]);
      check($sformatf("f0_a_c%0d", k), a_out, o_adr[k] ? 9'h155 : 9'h1FF);
    end
    check("f0_err", err_count, 16'd1);
    check("f0_q", q_out, 8'h5A);

    // Start requests at counter 3 and on the valid tick are both dropped.
    start_read(8'd3, 9'h003, 8'h00, 8'h00);
    nv      = 0;
    vpos    = -1;
    nfall   = 0;
    prev_rd = reading;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        nv++;
        vpos = k;
      end
      if (prev_rd === 1'b1 && reading === 1'b0) nfall++;
      prev_rd  = reading;
      start_in = (k == 3 || k == 12);
    end
    start_in = 1'b0;
    check("busy_valid_count", nv, 1);
    check("busy_valid_pos", vpos, 12);
    check("busy_reading_falls", nfall, 1);
    check("busy_idle_after", reading, 1'b0);

    // Reset asserted at counter 5 of an F = 2 read.
    start_read(8'd2, 9'h0F0, 8'h11, 8'h22);
    repeat (6) @(negedge clk_in);
    check("rmid_cen_before", cen_out, 1'b0);
    check("rmid_clk_before", clk_out, 1'b1);
    #2 reset_in = 1'b0;
    #1;
    check("rmid_cen", cen_out, 1'b1);
    check("rmid_clk", clk_out, 1'b1);
    check("rmid_a", a_out, 9'h1FF);
    check("rmid_err", err_count, 16'd0);
    check("rmid_valid", valid_out, 1'b0);
    check("rmid_reading", reading, 1'b0);
    @(negedge clk_in);
    reset_in = 1'b1;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) nv++;
    end
    check("rmid_no_valid", nv, 0);
    check("rmid_err_after", err_count, 16'd0);

    // Five mismatching reads: full counter counts, 2-bit counter saturates.
    sat_small = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      start_read(8'd1, 9'(i), 8'h00, 8'hFF);
      wait_valid($sformatf("sat%0d", i));
      check($sformatf("sat_err_full_%0d", i), err_count, 32'(i + 1));
      check($sformatf("sat_err_small_%0d", i), s_err_count, 32'(sat_small[i]));
      @(negedge clk_in);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_cycle.md
Name: read_cycle

Overview:
- Generates one complete SRAM read transaction per start request: SRAM clock, chip enable, write enable held high, and the 9-bit address.
- Captures the 8-bit SRAM output word and compares it against an expected value supplied by the FPGA test logic.
- Keeps a saturating mismatch count.
- Is the read-side counterpart of the existing SRAM write cycle generator and shares the same SRAM pins through the top-level mux (selected by the busy flags).

Parameters:
- CNT_W, 10, width of the phase counter; must hold 4*255 = 1020.
- ERR_W, 16, width of the mismatch counter.

Ports:
- clk_in  input  1  internal clock, 100 MHz
- reset_in  input  1  asynchronous, active-low reset; 0 = reset asserted
- clk_factor  input  8  phase length in clk_in ticks; value 0 is treated as 1
- start_in  input  1  single-tick start pulse
- a_in  input  9  read address
- exp_in  input  8  expected read value
- q_in  input  8  SRAM data output
- clk_out  output  1  SRAM clock
- cen_out  output  1  SRAM chip enable, active-low
- wen_out  output  1  SRAM write enable; held 1 for the whole read
- a_out  output  9  SRAM address
- q_out  output  8  captured read word
- valid_out  output  1  one-tick pulse when q_out and mismatch_out update
- mismatch_out  output  1  q_out != captured expected value; held until next valid
- err_count  output  ERR_W  saturating count of mismatches
- reading  output  1  high while a cycle is in progress

Behaviour:
- Reset (reset_in = 0, asynchronous):
  - Sets cycle = 0, counter = 0.
  - clk_out = 1, cen_out = 1, wen_out = 1, a_out = 9'h1FF.
  - q_out = 8'hFF, valid_out = 0, mismatch_out = 0, err_count = 0.
  - Reset release is synchronised (two flops) before use.
- start_in is registered once. Latency from start_in to reading = 1 is 2 clk_in ticks.
- Let F = max(clk_factor, 1). clk_factor is sampled at cycle start and held internally for the whole cycle. exp_in and a_in are latched at counter = 1.
- Cycle sequence, with counter counting ticks inside the cycle:
  - Start tick: cycle = 1, counter = 0.
  - counter = 0: clk_out = 0.
  - counter = 1: cen_out = 0, a_out = latched a_in; wen_out stays 1.
  - counter = 2F: clk_out = 1 (SRAM read launch edge).
  - counter = 4F-1: q_out = q_in, mismatch computed, cen_out = 1.
  - counter = 4F: valid_out = 1 for exactly one tick; err_count increments if mismatch; cycle returns to idle (clk_out = 1, a_out = 9'h1FF).
  - Every other tick: counter increments.
- F = 1 case: counter phases 0, 1, 2, 3, 4, so 5 ticks per cycle. This is the minimum legal cycle.
- States: IDLE, CLK_LOW, ADDR, CLK_HIGH, SAMPLE, DONE. The state transitions at counter thresholds listed above.
- start_in while reading = 1 is ignored. It is not queued.
- start_in on the same tick that DONE is reached is also ignored. A new cycle needs start_in while idle.
- err_count saturates at all-ones and never wraps.
- mismatch_out and q_out hold their values until the next valid_out.
- Reset mid-cycle:
  - Immediate abort; no valid_out pulse.
  - SRAM pins return to idle values in the same tick as reset assertion (asynchronous).
- Comparison is full 8-bit equality. There is no masking.

Decomposition:
- Shared include file, shared with the write cycle generator:
  - SRAM_ADDR_IDLE = 9'h1FF
  - SRAM_DATA_IDLE = 8'hFF
  - SRAM_ADDR_W = 9, SRAM_DATA_W = 8
  - CNT_W
  - state encodings for the read FSM
- One sub-module is natural: cycle_timer. It holds the phase counter plus the threshold decode (2F, 4F-1, 4F), produces one-hot phase strobes, and can be reused by the write generator.

Test Plan:
- Nominal read: clk_factor = 2, a_in = 9'h0A5, q_in = 8'h3C, exp_in = 8'h3C, pulse start_in.
  - clk_out falls at counter 0.
  - cen_out = 0 and a_out = 9'h0A5 at counter 1.
  - clk_out rises at counter 4.
  - Sample at counter 7; valid_out pulses at counter 8.
  - q_out = 8'h3C, mismatch_out = 0, err_count = 0, wen_out = 1 throughout.
- Mismatch: repeat with q_in = 8'h3D.
  - mismatch_out = 1, err_count = 1.
  - mismatch_out stays 1 until the next valid_out.
- clk_factor = 0: the cycle behaves as F = 1.
  - valid_out arrives 4 ticks after cycle start.
  - clk_out is low at counter 0–1 and high from counter 2.
- Start while busy: second start_in at counter 3 with clk_factor = 3.
  - Ignored: exactly one valid_out, and reading drops once.
- Reset mid-cycle: assert reset_in = 0 at counter 5.
  - cen_out = 1, clk_out = 1, a_out = 9'h1FF immediately.
  - No valid_out; err_count = 0.
- Saturation: force 65,536 mismatching reads (or preload via short ERR_W = 2 build, 5 mismatches).
  - err_count holds at all-ones (3 for the short build).
